// File: rtl/exec_cycle_counter.sv
// Execution profiler: counts cycles or retired instructions between start and stop.
// Optional decimal display counting is enabled by defining EXEC_COUNTER_BCD_EN.
module exec_cycle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             instr_done,
    input  logic             mode,
    output logic [WIDTH-1:0] count_out,
    output logic             counter_enable,
    output logic             running,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic             overflow_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] inc_val;
    logic             at_max;
    logic             inc_cond;

`ifdef EXEC_COUNTER_BCD_EN
    localparam int unsigned DIGITS = WIDTH / 4;

    function automatic logic [WIDTH-1:0] bcd_max();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'h9;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] bcd_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'h9) begin
                    r[4*i +: 4] = 4'h0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'h1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] MAX_VAL = bcd_max();

    assign inc_val = bcd_inc(count_out);
    assign at_max  = (count_out == MAX_VAL);
`else
    assign inc_val = count_out + 1'b1;
    assign at_max  = &count_out;
`endif

    assign inc_cond = mode_q ? instr_done : 1'b1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_out;
        overflow_d = overflow;
        mode_d     = mode_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    mode_d     = mode;
                end
            end
            RUN: begin
                if (inc_cond) begin
                    if (at_max) overflow_d = 1'b1;
                    else        count_d    = inc_val;
                end
                if (stop) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d    = IDLE;
            count_d    = '0;
            overflow_d = 1'b0;
            mode_d     = 1'b0;
        end
    end

    // Status flags are registered from the next state so they track the state register exactly.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= IDLE;
            count_out      <= '0;
            overflow       <= 1'b0;
            mode_q         <= 1'b0;
            counter_enable <= 1'b0;
            running        <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_out      <= count_d;
            overflow       <= overflow_d;
            mode_q         <= mode_d;
            counter_enable <= (state_d != IDLE);
            running        <= (state_d == RUN);
        end
    end

endmodule
